apb_bus_driver: RTL and testbench
=================================

# apb_bus_driver

Single-entry APB initiator running in the `system_clk` domain. It generates the divided `apb_clk` and sequences SETUP/ACCESS transfers on edges of that clock. It is the initiator side of the coprocessor's APB slave, which recovers `apb_clk` edges with its own edge detector. It serves as the test-harness and host-side bus driver for the add/sub and other FP units.

## Interface
Parameters:
- `ADDR_W`, 32: PADDR width.
- `DATA_W`, 32: PWDATA/PRDATA width.
- `HALF_PERIOD`, 4: `system_clk` cycles per `apb_clk` half period. Minimum 4, so the slave's 2-flop edge detector plus response logic settles within one half period.
- `TIMEOUT_CYC`, 16: `apb_clk` periods allowed in ACCESS without PREADY. Used only with `APB_DRV_TIMEOUT_EN`.

Ports:
- `system_clk`  in  1  sole clock.
- `nrst`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  command offered.
- `req_ready`  out  1  holding register empty; equals `!hold_full`.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  target address.
- `req_wdata`  in  DATA_W  write data.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  DATA_W  captured PRDATA; 0 for writes and timeouts.
- `rsp_err`  out  1  PSLVERR, or timeout.
- `rsp_timeout`  out  1  completion was a timeout abort.
- `apb_clk`  out  1  generated bus clock.
- `apb_rise`  out  1  high in the single `system_clk` cycle in which `apb_clk` first reads 1.
- `psel`, `penable`, `pwrite`  out  1  APB controls.
- `paddr`  out  ADDR_W.
- `pwdata`  out  DATA_W.
- `pready`, `pslverr`  in  1.
- `prdata`  in  DATA_W.

## Operation
- Divider: counter 0..HALF_PERIOD-1. At terminal count it wraps to 0 and toggles `apb_clk`. A rise event is the edge that sets `apb_clk` 0→1; `apb_rise` is registered alongside it.
- Command accept: on any `system_clk` edge with `req_valid && req_ready`, load the holding register and set `hold_full`. A freed slot is not refilled in the same cycle, because `req_ready` comes from the registered flag.
- FSM states IDLE, SETUP, ACCESS. All transitions, bus-signal updates and input sampling occur only on rise events. Inputs are sampled before the state update on that edge.
  - IDLE: if `hold_full`, drive `paddr`/`pwrite`/`pwdata` from the holding register, set `psel`=1 and `penable`=0, clear `hold_full`, and go to SETUP.
  - SETUP: set `penable`=1 and go to ACCESS.
  - ACCESS with `pready`=1: pulse `rsp_valid`. Capture `prdata` (read only) and `pslverr`. Then either:
    - if `hold_full`, go to SETUP with the new command loaded and `penable`=0, keeping `psel`=1 (back-to-back);
    - otherwise set `psel`=`penable`=0 and go to IDLE.
  - ACCESS with `pready`=0: hold all bus signals (wait state).
- `paddr`, `pwrite` and `pwdata` hold their last values in IDLE.
- Reset values: `apb_clk`=1, divider 0, state IDLE, `hold_full`=0 (so `req_ready`=1), all other outputs 0.
- Reset mid-transfer: the transfer is abandoned with no `rsp_valid`, and a held command is discarded.

## Timing
- First rise event: `system_clk` edge 2·HALF_PERIOD after the first edge sampling `nrst`=1.
- A command accepted while IDLE enters SETUP at the next rise event.
- Zero-wait transfer: `rsp_valid` asserts 2 `apb_clk` periods (4·HALF_PERIOD cycles) after the SETUP rise. Each wait state adds 1 period.
- `rsp_*` fields are valid only while `rsp_valid`=1 and hold until the next completion.
- Bus signals change only on rise-event edges and are stable for a full `apb_clk` period.

## Configuration
- `APB_DRV_TIMEOUT_EN` defined:
  - A counter increments on each ACCESS rise event with `pready`=0.
  - When it reaches TIMEOUT_CYC, the transfer terminates as if PREADY had arrived, with `rsp_err`=1, `rsp_timeout`=1 and `rsp_rdata`=0.
  - The counter clears on entry to SETUP.
- `APB_DRV_TIMEOUT_EN` undefined: ACCESS waits indefinitely; `rsp_timeout` is tied 0 and the counter is absent.

## Test plan
- Reset with HALF_PERIOD=4 → all outputs at reset values; first `apb_rise` 8 cycles after release; `apb_clk` period 8.
- Write 0xDEADBEEF to 0x10, `pready`=1 → SETUP shows `psel`=1, `penable`=0, `pwrite`=1, `paddr`=0x10; `rsp_valid` 16 cycles after the SETUP rise; `rsp_err`=0.
- Read from 0x20 with 2 wait states, `prdata`=0x3F800000 → `penable` held 3 periods; `rsp_rdata`=0x3F800000; `rsp_valid` 32 cycles after the SETUP rise.
- Two commands issued while busy → second accepted only after the first leaves the holding register; `psel` stays 1 across transfers; two `rsp_valid` pulses 16 cycles apart.
- `pslverr`=1 on a read → `rsp_err`=1, `rsp_timeout`=0.
- With `APB_DRV_TIMEOUT_EN` and TIMEOUT_CYC=16, `pready` held 0 → abort after 16 ACCESS periods: `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0. Separately, `nrst` pulsed low mid-ACCESS → no `rsp_valid`, `psel`=0 and `req_ready`=1 after reset.

Source files
------------

// File: rtl/apb_bus_driver.sv
// apb_bus_driver: single-entry APB initiator clocked by system_clk.
// Divides system_clk into apb_clk, which is high for HALF_PERIOD cycles and low for HALF_PERIOD
// cycles. Sequences SETUP/ACCESS transfers only on apb_clk rise events.
// A one-deep holding register accepts a command while a transfer is still in flight, which
// allows back-to-back transfers.
//
// Ports:
//   system_clk, nrst                    clock; synchronous active-low reset
//   req_valid/req_ready/req_write/
//   req_addr/req_wdata                  command handshake into the holding register
//   rsp_valid/rsp_rdata/rsp_err/
//   rsp_timeout                         one-cycle completion pulse with the captured response
//   apb_clk, apb_rise                   generated bus clock; registered rise marker
//   psel/penable/pwrite/paddr/pwdata    APB request outputs
//   pready/pslverr/prdata               APB completer responses
//
// Optional feature: define APB_DRV_TIMEOUT_EN to abort an ACCESS phase that sees no PREADY
// for TIMEOUT_CYC apb_clk periods.
module apb_bus_driver #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              system_clk,
  input  logic              nrst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              apb_clk,
  output logic              apb_rise,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic              pslverr,
  input  logic [DATA_W-1:0] prdata
);

  localparam int unsigned CntW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  // The completer needs a full half period to detect apb_clk edges and respond.
  if (HALF_PERIOD < 4 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("apb_bus_driver: HALF_PERIOD must be >= 4 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   div_q, div_d;
  logic              apb_clk_q, apb_clk_d;
  logic              rise_q, rise_d;
  logic              hold_full_q, hold_full_d;
  logic              hold_write_q, hold_write_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0] hold_wdata_q, hold_wdata_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              div_tc, rise_evt, load_bus, tmo_hit;

`ifdef APB_DRV_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            rsp_timeout_q, rsp_timeout_d;
  // Abort on the edge where this would be the TIMEOUT_CYC-th wait period.
  assign tmo_hit     = !pready && (tmo_q == TmoW'(TIMEOUT_CYC - 1));
  assign rsp_timeout = rsp_timeout_q;
`else
  assign tmo_hit     = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  assign div_tc   = (div_q == CntW'(HALF_PERIOD - 1));
  assign rise_evt = div_tc && !apb_clk_q;

  always_comb begin
    state_d      = state_q;
    div_d        = div_tc ? '0 : div_q + 1'b1;
    apb_clk_d    = div_tc ? !apb_clk_q : apb_clk_q;
    rise_d       = rise_evt;
    hold_full_d  = hold_full_q;
    hold_write_d = hold_write_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    load_bus     = 1'b0;
`ifdef APB_DRV_TIMEOUT_EN
    tmo_d         = tmo_q;
    rsp_timeout_d = rsp_timeout_q;
`endif

    // req_ready is the registered !hold_full, so accept and load never coincide.
    if (req_valid && !hold_full_q) begin
      hold_full_d  = 1'b1;
      hold_write_d = req_write;
      hold_addr_d  = req_addr;
      hold_wdata_d = req_wdata;
    end

    if (rise_evt) begin
      unique case (state_q)
        StIdle: begin
          if (hold_full_q) load_bus = 1'b1;
        end
        StSetup: begin
          penable_d = 1'b1;
          state_d   = StAccess;
        end
        StAccess: begin
          if (pready || tmo_hit) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = pslverr || tmo_hit;
            rsp_rdata_d = (pwrite_q || tmo_hit) ? '0 : prdata;
`ifdef APB_DRV_TIMEOUT_EN
            rsp_timeout_d = tmo_hit;
`endif
            if (hold_full_q) begin
              load_bus = 1'b1;
            end else begin
              psel_d    = 1'b0;
              penable_d = 1'b0;
              state_d   = StIdle;
            end
          end else begin
`ifdef APB_DRV_TIMEOUT_EN
            tmo_d = tmo_q + 1'b1;
`endif
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (load_bus) begin
      psel_d      = 1'b1;
      penable_d   = 1'b0;
      pwrite_d    = hold_write_q;
      paddr_d     = hold_addr_q;
      pwdata_d    = hold_wdata_q;
      hold_full_d = 1'b0;
      state_d     = StSetup;
`ifdef APB_DRV_TIMEOUT_EN
      tmo_d = '0;
`endif
    end
  end

  always_ff @(posedge system_clk) begin
    if (!nrst) begin
      state_q      <= StIdle;
      div_q        <= '0;
      apb_clk_q    <= 1'b1;
      rise_q       <= 1'b0;
      hold_full_q  <= 1'b0;
      hold_write_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
`ifdef APB_DRV_TIMEOUT_EN
      tmo_q         <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      apb_clk_q    <= apb_clk_d;
      rise_q       <= rise_d;
      hold_full_q  <= hold_full_d;
      hold_write_q <= hold_write_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
`ifdef APB_DRV_TIMEOUT_EN
      tmo_q         <= tmo_d;
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  assign req_ready = !hold_full_q;
  assign apb_clk   = apb_clk_q;
  assign apb_rise  = rise_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_bus_driver.sv
// Testbench for apb_bus_driver: a behavioural APB completer, an event log, and one task per
// scenario, each comparing logged events against expectations derived from the transaction list.
module tb_apb_bus_driver;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned HP = 4;
  localparam int unsigned TO = 16;
  localparam int unsigned PER = 2 * HP;

  logic          system_clk = 1'b0;
  logic          nrst = 1'b0;
  logic          req_valid = 1'b0, req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, rsp_valid, rsp_err, rsp_timeout, apb_clk, apb_rise;
  logic [DW-1:0] rsp_rdata, pwdata, prdata = '0;
  logic          psel, penable, pwrite, pready = 1'b0, pslverr = 1'b0;
  logic [AW-1:0] paddr;

  int errors = 0;
  int checks = 0;

  apb_bus_driver #(.ADDR_W(AW), .DATA_W(DW), .HALF_PERIOD(HP), .TIMEOUT_CYC(TO)) dut (
    .system_clk(system_clk), .nrst(nrst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .apb_clk(apb_clk), .apb_rise(apb_rise),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  always #5 system_clk = ~system_clk;

  // Event log, filled by the monitor below.
  int unsigned   cyc = 0;
  int unsigned   setup_cyc_q[$];
  logic [AW-1:0] setup_addr_q[$];
  logic          setup_write_q[$];
  logic [DW-1:0] setup_wdata_q[$];
  int unsigned   rsp_cyc_q[$];
  logic [DW-1:0] rsp_rdata_q[$];
  logic          rsp_err_q[$], rsp_to_q[$], rsp_psel_q[$];
  int unsigned   penable_cyc = 0;
  int unsigned   bad_change = 0;

  // Completer behaviour for each transfer, in issue order.
  int unsigned   cfg_waits_q[$];
  logic [DW-1:0] cfg_rdata_q[$];
  logic          cfg_err_q[$];
  int unsigned   cur_waits = 0, wcnt = 0;
  logic          cur_err = 1'b0;
  logic [AW+DW+2:0] prev_bus = '0;
  logic          prev_ok = 1'b0;

  // Samples 1 time unit after each posedge; also acts as the APB completer.
  always @(posedge system_clk) begin
    #1;
    cyc++;
    if (!nrst) begin
      pready = 1'b0; pslverr = 1'b0; wcnt = 0;
    end else begin
      if (prev_ok && !apb_rise && {psel, penable, pwrite, paddr, pwdata} !== prev_bus)
        bad_change++;
      if (penable) penable_cyc++;
      if (apb_rise) begin
        if (psel && !penable) begin
          setup_cyc_q.push_back(cyc); setup_addr_q.push_back(paddr);
          setup_write_q.push_back(pwrite); setup_wdata_q.push_back(pwdata);
          if (cfg_waits_q.size() > 0) begin
            cur_waits = cfg_waits_q.pop_front(); prdata = cfg_rdata_q.pop_front();
            cur_err = cfg_err_q.pop_front();
          end else begin
            cur_waits = 0; prdata = '0; cur_err = 1'b0;
          end
          wcnt = 0; pready = 1'b0; pslverr = 1'b0;
        end else if (psel && penable) begin
          if (wcnt >= cur_waits) begin
            pready = 1'b1; pslverr = cur_err;
          end else begin
            pready = 1'b0; pslverr = 1'b0; wcnt++;
          end
        end else begin
          pready = 1'b0; pslverr = 1'b0;
        end
      end
      if (rsp_valid) begin
        rsp_cyc_q.push_back(cyc); rsp_rdata_q.push_back(rsp_rdata);
        rsp_err_q.push_back(rsp_err); rsp_to_q.push_back(rsp_timeout);
        rsp_psel_q.push_back(psel);
      end
    end
    prev_bus = {psel, penable, pwrite, paddr, pwdata};
    prev_ok  = nrst;
  end

  task automatic clear_logs();
    setup_cyc_q.delete(); setup_addr_q.delete(); setup_write_q.delete();
    setup_wdata_q.delete(); rsp_cyc_q.delete(); rsp_rdata_q.delete(); rsp_err_q.delete();
    rsp_to_q.delete(); rsp_psel_q.delete(); cfg_waits_q.delete(); cfg_rdata_q.delete();
    cfg_err_q.delete(); penable_cyc = 0;
  endtask

  task automatic push_cfg(input int unsigned waits, input logic [DW-1:0] rd, input logic err);
    cfg_waits_q.push_back(waits); cfg_rdata_q.push_back(rd); cfg_err_q.push_back(err);
  endtask

  // Offers a command and returns the cycle of the accepting edge.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output int unsigned acc);
    int n = 0;
    @(negedge system_clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    while (!req_ready && n < 200) begin @(negedge system_clk); n++; end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL issue_accept: req_ready=%0b after %0d cycles, want 1", req_ready, n);
    end
    @(negedge system_clk);
    acc = cyc; req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int unsigned n, input int unsigned limit);
    int unsigned k = 0;
    while (rsp_cyc_q.size() < n && k < limit) begin @(negedge system_clk); k++; end
    repeat (2) @(negedge system_clk);
    checks++;
    if (rsp_cyc_q.size() != n) begin
      errors++; $display("FAIL rsp_count: got %0d responses, want %0d", rsp_cyc_q.size(), n);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "response wait expired");
    end
  endtask

  task automatic test_reset();
    int n;
    nrst = 1'b0;
    repeat (4) @(negedge system_clk);
    checks += 6;
    if (apb_clk !== 1'b1) begin errors++; $display("FAIL rst_apb_clk: got %b want 1", apb_clk); end
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    if ({psel, penable, pwrite, apb_rise} !== 4'b0) begin
      errors++; $display("FAIL rst_ctrl: got %b want 0000", {psel, penable, pwrite, apb_rise});
    end
    if (paddr !== '0) begin errors++; $display("FAIL rst_paddr: got %h want 0", paddr); end
    if (pwdata !== '0) begin errors++; $display("FAIL rst_pwdata: got %h want 0", pwdata); end
    if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== '0) begin
      errors++; $display("FAIL rst_rsp: got %b %b %b %h want all 0", rsp_valid, rsp_err,
                         rsp_timeout, rsp_rdata);
    end
    nrst = 1'b1;
    n = 0;
    do begin @(negedge system_clk); n++; end while (!apb_rise && n < 64);
    checks++;
    if (n != PER) begin errors++; $display("FAIL first_rise: got %0d cycles want %0d", n, PER); end
    n = 0;
    do begin @(negedge system_clk); n++; end while (!apb_rise && n < 64);
    checks += 2;
    if (n != PER) begin errors++; $display("FAIL apb_period: got %0d want %0d", n, PER); end
    if (apb_clk !== 1'b1) begin errors++; $display("FAIL rise_level: got %b want 1", apb_clk); end
  endtask

  task automatic test_write();
    int unsigned acc;
    clear_logs();
    push_cfg(0, 32'h1234_5678, 1'b0);
    issue(1'b1, 32'h10, 32'hDEAD_BEEF, acc);
    wait_rsp(1, 200);
    checks += 8;
    if (setup_addr_q[0] !== 32'h10) begin errors++; $display("FAIL wr_paddr: got %h want 10", setup_addr_q[0]); end
    if (setup_write_q[0] !== 1'b1) begin errors++; $display("FAIL wr_pwrite: got %b want 1", setup_write_q[0]); end
    if (setup_wdata_q[0] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_pwdata: got %h want deadbeef", setup_wdata_q[0]);
    end
    if (setup_cyc_q[0] <= acc || setup_cyc_q[0] - acc > PER) begin
      errors++; $display("FAIL wr_setup_delay: got %0d want 1..%0d", setup_cyc_q[0] - acc, PER);
    end
    if (rsp_cyc_q[0] - setup_cyc_q[0] != 2 * PER) begin
      errors++; $display("FAIL wr_latency: got %0d want %0d", rsp_cyc_q[0] - setup_cyc_q[0], 2 * PER);
    end
    if (rsp_err_q[0] !== 1'b0 || rsp_to_q[0] !== 1'b0) begin
      errors++; $display("FAIL wr_err: got %b%b want 00", rsp_err_q[0], rsp_to_q[0]);
    end
    if (rsp_rdata_q[0] !== '0) begin errors++; $display("FAIL wr_rdata: got %h want 0", rsp_rdata_q[0]); end
    if (rsp_psel_q[0] !== 1'b0) begin errors++; $display("FAIL wr_idle: psel got %b want 0", rsp_psel_q[0]); end
  endtask

  task automatic test_read_wait();
    int unsigned acc;
    clear_logs();
    push_cfg(2, 32'h3F80_0000, 1'b0);
    issue(1'b0, 32'h20, 32'h0, acc);
    wait_rsp(1, 300);
    checks += 5;
    if (setup_addr_q[0] !== 32'h20 || setup_write_q[0] !== 1'b0) begin
      errors++; $display("FAIL rd_setup: got %h/%b want 20/0", setup_addr_q[0], setup_write_q[0]);
    end
    if (rsp_cyc_q[0] - setup_cyc_q[0] != 4 * PER) begin
      errors++; $display("FAIL rd_latency: got %0d want %0d", rsp_cyc_q[0] - setup_cyc_q[0], 4 * PER);
    end
    if (penable_cyc != 3 * PER) begin
      errors++; $display("FAIL rd_penable: got %0d cycles want %0d", penable_cyc, 3 * PER);
    end
    if (rsp_rdata_q[0] !== 32'h3F80_0000) begin
      errors++; $display("FAIL rd_rdata: got %h want 3f800000", rsp_rdata_q[0]);
    end
    if (rsp_err_q[0] !== 1'b0) begin errors++; $display("FAIL rd_err: got %b want 0", rsp_err_q[0]); end
  endtask

  task automatic test_slverr();
    int unsigned acc;
    logic [DW-1:0] rd;
    clear_logs();
    rd = $urandom;
    push_cfg(1, rd, 1'b1);
    issue(1'b0, $urandom, 32'h0, acc);
    wait_rsp(1, 300);
    checks += 3;
    if (rsp_err_q[0] !== 1'b1) begin errors++; $display("FAIL slverr_err: got %b want 1", rsp_err_q[0]); end
    if (rsp_to_q[0] !== 1'b0) begin errors++; $display("FAIL slverr_to: got %b want 0", rsp_to_q[0]); end
    if (rsp_rdata_q[0] !== rd) begin errors++; $display("FAIL slverr_rdata: got %h want %h", rsp_rdata_q[0], rd); end
  endtask

  task automatic test_back_to_back();
    int unsigned acc_a, acc_b;
    clear_logs();
    push_cfg(0, 32'hAAAA_0001, 1'b0);
    push_cfg(0, 32'hBBBB_0002, 1'b0);
    issue(1'b1, 32'h100, 32'h1111_1111, acc_a);
    issue(1'b0, 32'h104, 32'h0, acc_b);
    wait_rsp(2, 300);
    checks += 6;
    if (acc_b <= setup_cyc_q[0]) begin
      errors++; $display("FAIL b2b_accept: got cycle %0d want > %0d", acc_b, setup_cyc_q[0]);
    end
    if (setup_cyc_q[1] != rsp_cyc_q[0]) begin
      errors++; $display("FAIL b2b_setup: got %0d want %0d", setup_cyc_q[1], rsp_cyc_q[0]);
    end
    if (rsp_psel_q[0] !== 1'b1 || rsp_psel_q[1] !== 1'b0) begin
      errors++; $display("FAIL b2b_psel: got %b%b want 10", rsp_psel_q[0], rsp_psel_q[1]);
    end
    if (rsp_cyc_q[1] - rsp_cyc_q[0] != 2 * PER) begin
      errors++; $display("FAIL b2b_gap: got %0d want %0d", rsp_cyc_q[1] - rsp_cyc_q[0], 2 * PER);
    end
    if (rsp_rdata_q[0] !== '0) begin errors++; $display("FAIL b2b_rdata0: got %h want 0", rsp_rdata_q[0]); end
    if (rsp_rdata_q[1] !== 32'hBBBB_0002) begin
      errors++; $display("FAIL b2b_rdata1: got %h want bbbb0002", rsp_rdata_q[1]);
    end
  endtask

  task automatic test_random();
    localparam int N = 10;
    logic          w[N], e[N];
    logic [AW-1:0] a[N];
    logic [DW-1:0] d[N], r[N];
    int unsigned   wt[N];
    int unsigned   acc;
    clear_logs();
    for (int i = 0; i < N; i++) begin
      w[i] = 1'($urandom); e[i] = ($urandom_range(0, 3) == 0); a[i] = $urandom;
      d[i] = $urandom; r[i] = $urandom; wt[i] = $urandom_range(0, 3);
      push_cfg(wt[i], r[i], e[i]);
    end
    for (int i = 0; i < N; i++) issue(w[i], a[i], d[i], acc);
    wait_rsp(N, 800);
    for (int i = 0; i < N; i++) begin
      checks += 4;
      if ({setup_write_q[i], setup_addr_q[i], setup_wdata_q[i]} !== {w[i], a[i], d[i]}) begin
        errors++; $display("FAIL rnd_setup[%0d]: got %b %h %h want %b %h %h", i, setup_write_q[i],
                           setup_addr_q[i], setup_wdata_q[i], w[i], a[i], d[i]);
      end
      if (rsp_rdata_q[i] !== (w[i] ? '0 : r[i])) begin
        errors++; $display("FAIL rnd_rdata[%0d]: got %h want %h", i, rsp_rdata_q[i], w[i] ? '0 : r[i]);
      end
      if ({rsp_err_q[i], rsp_to_q[i]} !== {e[i], 1'b0}) begin
        errors++; $display("FAIL rnd_err[%0d]: got %b%b want %b0", i, rsp_err_q[i], rsp_to_q[i], e[i]);
      end
      if (rsp_cyc_q[i] - setup_cyc_q[i] != (2 + wt[i]) * PER) begin
        errors++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", i,
                           rsp_cyc_q[i] - setup_cyc_q[i], (2 + wt[i]) * PER);
      end
    end
  endtask

`ifdef APB_DRV_TIMEOUT_EN
  task automatic test_timeout();
    int unsigned acc;
    clear_logs();
    push_cfg(1000, 32'hCAFE_F00D, 1'b0);
    issue(1'b0, 32'h40, 32'h0, acc);
    wait_rsp(1, 400);
    checks += 2;
    if (rsp_cyc_q[0] - setup_cyc_q[0] != (TO + 1) * PER) begin
      errors++; $display("FAIL to_latency: got %0d want %0d", rsp_cyc_q[0] - setup_cyc_q[0], (TO + 1) * PER);
    end
    if ({rsp_err_q[0], rsp_to_q[0], rsp_rdata_q[0]} !== {2'b11, 32'h0}) begin
      errors++; $display("FAIL to_rsp: got %b %b %h want 1 1 0", rsp_err_q[0], rsp_to_q[0], rsp_rdata_q[0]);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int unsigned acc;
    int k = 0;
    clear_logs();
    push_cfg(20, 32'h5555_AAAA, 1'b0);
    push_cfg(0, 32'h0, 1'b0);
    issue(1'b0, 32'h80, 32'h0, acc);
    while (setup_cyc_q.size() == 0 && k < 100) begin @(negedge system_clk); k++; end
    repeat (3 * PER) @(negedge system_clk);
    issue(1'b1, 32'h84, 32'h7777_7777, acc);
    nrst = 1'b0;
    repeat (3) @(negedge system_clk);
    nrst = 1'b1;
    @(negedge system_clk);
    checks += 3;
    if (psel !== 1'b0) begin errors++; $display("FAIL midrst_psel: got %b want 0", psel); end
    if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", req_ready); end
    if (penable !== 1'b0) begin errors++; $display("FAIL midrst_penable: got %b want 0", penable); end
    repeat (10 * PER) @(negedge system_clk);
    checks += 2;
    if (rsp_cyc_q.size() != 0) begin errors++; $display("FAIL midrst_rsp: got %0d want 0", rsp_cyc_q.size()); end
    if (setup_cyc_q.size() != 1) begin
      errors++; $display("FAIL midrst_held: got %0d setups want 1", setup_cyc_q.size());
    end
    clear_logs();
  endtask

  task automatic test_stability();
    checks++;
    if (bad_change != 0) begin
      errors++; $display("FAIL bus_stable: got %0d off-edge changes want 0", bad_change);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_back_to_back();
    test_random();
`ifdef APB_DRV_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    test_stability();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
